// File: rtl/cflog_ctrl_pkg.sv
// Shared encodings and defaults for the CF-Log write sequencer.
package cflog_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_SRC = 2'd1,
        ST_WR_DST = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_NONE = 2'b00;
    localparam logic [1:0] FLUSH_FULL = 2'b01;
    localparam logic [1:0] FLUSH_ER   = 2'b10;
    localparam logic [1:0] FLUSH_BOOT = 2'b11;

    localparam logic [15:0] LOG_BASE_DEF  = 16'h0240;
    localparam int          LOG_WORDS_DEF = 256;
    localparam int          PTR_W_DEF     = 9;

    // Byte address of a 16-bit log word; wraps mod 2^16.
    function automatic logic [15:0] log_addr(input logic [15:0] base, input logic [15:0] word_idx);
        return base + {word_idx[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/cflog_ctrl_if.sv
// Entry, log-RAM and flush handshake bundle for cflog_ctrl.
interface cflog_ctrl_if #(parameter int PTR_W = 9);

    logic             ent_valid;
    logic [15:0]      ent_src;
    logic [15:0]      ent_dest;
    logic             ent_ready;
    logic             er_done;
    logic             boot;
    logic             mem_busy;
    logic             mem_wen;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic [PTR_W-1:0] log_ptr;
    logic             flush_req;
    logic [1:0]       flush_reason;
    logic             flush_ack;

    modport master (
        input  ent_valid, ent_src, ent_dest, er_done, boot, mem_busy, flush_ack,
        output ent_ready, mem_wen, mem_addr, mem_wdata, log_ptr, flush_req, flush_reason
    );

    modport slave (
        output ent_valid, ent_src, ent_dest, er_done, boot, mem_busy, flush_ack,
        input  ent_ready, mem_wen, mem_addr, mem_wdata, log_ptr, flush_req, flush_reason
    );

endinterface

// File: rtl/cflog_ctrl.sv
// CF-Log writer: stores (src,dest) pairs as two log words and runs the
// flush req/ack handshake with the attestation TCB.
module cflog_ctrl
    import cflog_ctrl_pkg::*;
#(
    parameter logic [15:0] LOG_BASE  = LOG_BASE_DEF,
    parameter int          LOG_WORDS = LOG_WORDS_DEF,
    parameter int          PTR_W     = PTR_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    cflog_ctrl_if.master bus
);

    localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(LOG_WORDS);
    localparam logic [PTR_W-1:0] PTR_READY = PTR_W'(LOG_WORDS - 2);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [15:0]      src_q, src_d;
    logic [15:0]      dst_q, dst_d;
    logic [1:0]       reason_q, reason_d;
    logic             pend_er_q, pend_er_d;
    logic             pend_boot_q, pend_boot_d;
    logic             ent_ready;
    logic             wr_active;
    logic [PTR_W-1:0] ptr_inc;

    assign ptr_inc   = ptr_q + 1'b1;
    assign ent_ready = (state_q == ST_IDLE) && !pend_er_q && !pend_boot_q && (ptr_q <= PTR_READY);
    assign wr_active = (state_q == ST_WR_SRC) || (state_q == ST_WR_DST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        src_d       = src_q;
        dst_d       = dst_q;
        reason_d    = reason_q;
        pend_er_d   = pend_er_q | bus.er_done;
        pend_boot_d = pend_boot_q | bus.boot;
        case (state_q)
            ST_IDLE: begin
                if (bus.ent_valid && ent_ready) begin
                    src_d   = bus.ent_src;
                    dst_d   = bus.ent_dest;
                    state_d = ST_WR_SRC;
                end else if (pend_boot_q) begin
                    reason_d = FLUSH_BOOT;
                    state_d  = ST_FLUSH;
                end else if (pend_er_q) begin
                    reason_d = FLUSH_ER;
                    state_d  = ST_FLUSH;
                end
            end
            ST_WR_SRC: begin
                if (!bus.mem_busy) begin
                    ptr_d   = ptr_inc;
                    state_d = ST_WR_DST;
                end
            end
            ST_WR_DST: begin
                if (!bus.mem_busy) begin
                    ptr_d = ptr_inc;
                    // A full log outranks pending ER/boot; those are served after.
                    if (ptr_inc == PTR_FULL) begin
                        reason_d = FLUSH_FULL;
                        state_d  = ST_FLUSH;
                    end else if (pend_boot_q) begin
                        reason_d = FLUSH_BOOT;
                        state_d  = ST_FLUSH;
                    end else if (pend_er_q) begin
                        reason_d = FLUSH_ER;
                        state_d  = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.flush_ack) begin
                    // A pulse landing on the ack cycle must survive the clear.
                    if (reason_q == FLUSH_BOOT) pend_boot_d = bus.boot;
                    if (reason_q == FLUSH_ER)   pend_er_d   = bus.er_done;
                    ptr_d    = '0;
                    reason_d = FLUSH_NONE;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            reason_q    <= FLUSH_NONE;
            pend_er_q   <= 1'b0;
            pend_boot_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            reason_q    <= reason_d;
            pend_er_q   <= pend_er_d;
            pend_boot_q <= pend_boot_d;
        end
    end

    assign bus.ent_ready    = ent_ready;
    assign bus.mem_wen      = wr_active && !bus.mem_busy;
    assign bus.mem_addr     = wr_active ? log_addr(LOG_BASE, 16'(ptr_q)) : 16'h0000;
    assign bus.mem_wdata    = (state_q == ST_WR_SRC) ? src_q :
                              (state_q == ST_WR_DST) ? dst_q : 16'h0000;
    assign bus.log_ptr      = ptr_q;
    assign bus.flush_req    = (state_q == ST_FLUSH);
    assign bus.flush_reason = reason_q;

endmodule

// File: tb/tb_cflog_ctrl.sv
// Directed bench for cflog_ctrl with a 4-word log.
module tb_cflog_ctrl;

    localparam int PTR_W = 3;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    cflog_ctrl_if #(.PTR_W(PTR_W)) bus ();

    cflog_ctrl #(
        .LOG_BASE (16'h0240),
        .LOG_WORDS(4),
        .PTR_W    (PTR_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic wen, input logic [15:0] addr, input logic [15:0] wd);
        chk({tag, ".wen"},   32'(bus.mem_wen),   32'(wen));
        chk({tag, ".addr"},  32'(bus.mem_addr),  32'(addr));
        chk({tag, ".wdata"}, 32'(bus.mem_wdata), 32'(wd));
    endtask

    task automatic chk_fl(input string tag, input logic req, input logic [1:0] rsn, input logic rdy);
        chk({tag, ".req"},    32'(bus.flush_req),    32'(req));
        chk({tag, ".reason"}, 32'(bus.flush_reason), 32'(rsn));
        chk({tag, ".ready"},  32'(bus.ent_ready),    32'(rdy));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n       = 1'b0;
        bus.ent_valid = 1'b0;
        bus.ent_src   = '0;
        bus.ent_dest  = '0;
        bus.er_done   = 1'b0;
        bus.boot      = 1'b0;
        bus.mem_busy  = 1'b0;
        bus.flush_ack = 1'b0;
        #2;
        chk_wr("rst", 1'b0, 16'h0000, 16'h0000);
        chk_fl("rst", 1'b0, 2'b00, 1'b1);
        chk("rst.ptr", 32'(bus.log_ptr), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Entry 1: E000/E010 at word 0
        bus.ent_valid = 1'b1; bus.ent_src = 16'hE000; bus.ent_dest = 16'hE010;
        chk("e1.ready", 32'(bus.ent_ready), 32'd1);
        tick();
        bus.ent_valid = 1'b0;
        chk_wr("e1.src", 1'b1, 16'h0240, 16'hE000);
        chk("e1.busyready", 32'(bus.ent_ready), 32'd0);
        tick();
        chk_wr("e1.dst", 1'b1, 16'h0242, 16'hE010);
        tick();
        chk_wr("e1.idle", 1'b0, 16'h0000, 16'h0000);
        chk("e1.ptr", 32'(bus.log_ptr), 32'd2);
        chk("e1.ready_back", 32'(bus.ent_ready), 32'd1);

        // Entry 2 fills the 4-word log
        bus.ent_valid = 1'b1; bus.ent_src = 16'hA001; bus.ent_dest = 16'hA002;
        tick();
        bus.ent_valid = 1'b0;
        chk_wr("e2.src", 1'b1, 16'h0244, 16'hA001);
        tick();
        chk_wr("e2.dst", 1'b1, 16'h0246, 16'hA002);
        tick();
        chk_fl("full", 1'b1, 2'b01, 1'b0);
        chk("full.ptr", 32'(bus.log_ptr), 32'd4);
        chk("full.wen", 32'(bus.mem_wen), 32'd0);

        // Boot pulse while the FULL flush is outstanding
        bus.boot = 1'b1;
        tick();
        bus.boot = 1'b0;
        chk_fl("full.hold", 1'b1, 2'b01, 1'b0);
        tick();
        bus.flush_ack = 1'b1;
        tick();
        bus.flush_ack = 1'b0;
        chk_fl("ack1", 1'b0, 2'b00, 1'b0);
        chk("ack1.ptr", 32'(bus.log_ptr), 32'd0);
        tick();
        chk_fl("bootfl", 1'b1, 2'b11, 1'b0);
        bus.flush_ack = 1'b1;
        tick();
        bus.flush_ack = 1'b0;
        chk_fl("ack2", 1'b0, 2'b00, 1'b1);

        // Stray ack in IDLE
        bus.flush_ack = 1'b1;
        tick();
        bus.flush_ack = 1'b0;
        tick();
        chk_fl("stray", 1'b0, 2'b00, 1'b1);
        chk("stray.ptr", 32'(bus.log_ptr), 32'd0);

        // mem_busy for 3 cycles in WR_SRC
        bus.ent_valid = 1'b1; bus.ent_src = 16'hE000; bus.ent_dest = 16'hE010;
        bus.mem_busy  = 1'b1;
        tick();
        bus.ent_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_wr($sformatf("busy%0d", i), 1'b0, 16'h0240, 16'hE000);
            chk($sformatf("busy%0d.ptr", i), 32'(bus.log_ptr), 32'd0);
            if (i < 2) tick();
        end
        tick();
        bus.mem_busy = 1'b0;
        #1;
        chk_wr("busy.src", 1'b1, 16'h0240, 16'hE000);
        tick();
        chk_wr("busy.dst", 1'b1, 16'h0242, 16'hE010);
        tick();
        chk("busy.ptr", 32'(bus.log_ptr), 32'd2);
        chk("busy.ready", 32'(bus.ent_ready), 32'd1);

        // Async reset during WR_DST drops the entry
        bus.ent_valid = 1'b1; bus.ent_src = 16'h1111; bus.ent_dest = 16'h2222;
        tick();
        bus.ent_valid = 1'b0;
        tick();
        chk_wr("r6.dst", 1'b1, 16'h0246, 16'h2222);
        reset_n = 1'b0;
        #1;
        chk_wr("r6.rst", 1'b0, 16'h0000, 16'h0000);
        chk("r6.ptr", 32'(bus.log_ptr), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        chk_fl("r6.rel", 1'b0, 2'b00, 1'b1);

        // Entry accepted in the same cycle as er_done
        bus.ent_valid = 1'b1; bus.ent_src = 16'h1234; bus.ent_dest = 16'h5678;
        bus.er_done   = 1'b1;
        tick();
        bus.ent_valid = 1'b0;
        bus.er_done   = 1'b0;
        chk_wr("er.src", 1'b1, 16'h0240, 16'h1234);
        tick();
        chk_wr("er.dst", 1'b1, 16'h0242, 16'h5678);
        tick();
        chk_fl("er.fl", 1'b1, 2'b10, 1'b0);
        chk("er.ptr", 32'(bus.log_ptr), 32'd2);
        tick();
        chk_fl("er.hold", 1'b1, 2'b10, 1'b0);
        bus.flush_ack = 1'b1;
        tick();
        bus.flush_ack = 1'b0;
        chk_fl("er.ack", 1'b0, 2'b00, 1'b1);
        chk("er.ackptr", 32'(bus.log_ptr), 32'd0);
        tick();
        chk_fl("er.done", 1'b0, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
